// File: rtl/chip8_alu_sequencer.sv
// CHIP-8 8XYN sequencer: reads VX/VY, drives the shared ALU, writes VX then VF.
// Optional macro CHIP8_VF_RESET_QUIRK_EN: OR/AND/XOR also clear VF (COSMAC VIP behaviour).
module chip8_alu_sequencer #(
  parameter int REG_AW = 4,
  parameter int DW     = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [15:0]       opcode,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [REG_AW-1:0] rf_raddr,
  input  logic [DW-1:0]     rf_rdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DW-1:0]     rf_wdata,
  output logic [DW-1:0]     alu_x,
  output logic [DW-1:0]     alu_y,
  output logic [2:0]        alu_op,
  input  logic [DW-1:0]     alu_out,
  input  logic              alu_carry
);

  typedef enum logic [2:0] {
    IDLE, RD_X, RD_Y, EXEC, ALU, WR_X, WR_F, DONE
  } state_t;

  typedef struct packed {
    logic       legal;
    logic [2:0] op;
    logic       swap;
    logic       vfw;
    logic       vf_zero;
  } dec_t;

  function automatic dec_t decode(input logic [3:0] n);
    dec_t d;
    d = '0;
    d.legal = 1'b1;
    unique case (n)
      4'h0: d.op = 3'd0;
      4'h1, 4'h2, 4'h3: begin
        d.op = n[2:0];
`ifdef CHIP8_VF_RESET_QUIRK_EN
        d.vfw     = 1'b1;
        d.vf_zero = 1'b1;
`endif
      end
      4'h4: begin d.op = 3'd4; d.vfw = 1'b1; end
      4'h5: begin d.op = 3'd5; d.vfw = 1'b1; end
      4'h6: begin d.op = 3'd6; d.vfw = 1'b1; end
      4'h7: begin d.op = 3'd5; d.vfw = 1'b1; d.swap = 1'b1; end
      4'hE: begin d.op = 3'd7; d.vfw = 1'b1; end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

  state_t            r_state, w_nxt;
  logic [REG_AW-1:0] r_x, r_y;
  logic [3:0]        r_n;
  logic              r_ill;
  logic [DW-1:0]     r_opx, r_opy, r_res;
  logic              r_flg;
  dec_t              w_dec_in, w_dec;
  logic              w_unused_opc;

  assign w_unused_opc = &{1'b0, opcode[15:12]};
  assign w_dec_in     = decode(opcode[3:0]);
  assign w_dec        = decode(r_n);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x   <= '0;
      r_y   <= '0;
      r_n   <= '0;
      r_ill <= 1'b0;
      r_opx <= '0;
      r_opy <= '0;
      r_res <= '0;
      r_flg <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: if (start) begin
          r_x   <= REG_AW'(opcode[11:8]);
          r_y   <= REG_AW'(opcode[7:4]);
          r_n   <= opcode[3:0];
          r_ill <= ~w_dec_in.legal;
        end
        RD_Y: r_opx <= rf_rdata;
        EXEC: r_opy <= rf_rdata;
        ALU: begin
          r_res <= alu_out;
          r_flg <= alu_carry;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode purely from state so a reset zeroes them immediately.
  always_comb begin
    w_nxt    = r_state;
    busy     = (r_state != IDLE);
    done     = 1'b0;
    illegal  = 1'b0;
    rf_raddr = '0;
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    alu_x    = '0;
    alu_y    = '0;
    alu_op   = '0;
    unique case (r_state)
      IDLE: if (start) w_nxt = w_dec_in.legal ? RD_X : DONE;
      RD_X: begin
        rf_raddr = r_x;
        w_nxt    = RD_Y;
      end
      RD_Y: begin
        rf_raddr = r_y;
        w_nxt    = EXEC;
      end
      EXEC: w_nxt = ALU;
      ALU: begin
        alu_x  = w_dec.swap ? r_opy : r_opx;
        alu_y  = w_dec.swap ? r_opx : r_opy;
        alu_op = w_dec.op;
        w_nxt  = WR_X;
      end
      WR_X: begin
        rf_we    = 1'b1;
        rf_waddr = r_x;
        rf_wdata = r_res;
        w_nxt    = w_dec.vfw ? WR_F : DONE;
      end
      WR_F: begin
        rf_we    = 1'b1;
        rf_waddr = {REG_AW{1'b1}};
        rf_wdata = w_dec.vf_zero ? '0 : {{(DW-1){1'b0}}, r_flg};
        w_nxt    = DONE;
      end
      DONE: begin
        done    = 1'b1;
        illegal = r_ill;
        w_nxt   = IDLE;
      end
      default: w_nxt = IDLE;
    endcase
  end

endmodule
